// File: rtl/mac_accumulator_pkg.sv
// Shared types for the MAC accumulator: configuration record, accumulate opcodes
// and the 32-bit saturation helper.
package mac_accumulator_pkg;

   typedef struct packed {
      int unsigned xlen;
      int unsigned trans_id_bits;
   } mac_cfg_t;

   localparam mac_cfg_t cva6_cfg_empty = '{xlen: 64, trans_id_bits: 3};

   typedef enum logic [1:0] {
      MAC_ACC  = 2'd0,
      MAC_NEW  = 2'd1,
      MAC_RDQ  = 2'd2,
      MAC_PEEK = 2'd3
   } mac_acc_op_t;

   // Clamp a 33-bit two's-complement sum back into signed 32-bit range.
   function automatic logic [31:0] sat32(input logic [32:0] s);
      if (s[32] != s[31]) begin
         return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
      return s[31:0];
   endfunction

endpackage

// File: rtl/mac_tag_fifo.sv
// Small synchronous FIFO with flush, shared by the tag queue and the result queue.
module mac_tag_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push, do_pop;

   assign empty_o = (count == '0);
   assign count_o = count;
   assign data_o  = mem[rd_ptr];
   assign do_pop  = pop_i && !empty_o;
   // A pop in the same cycle frees the slot a full-queue push needs.
   assign do_push = push_i && ((count != FULL_CNT) || do_pop);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= data_i;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mac_accumulator.sv
// Accumulates MAC dot products per issued tag and returns requantised or raw
// accumulator values through a result queue sized so MAC results never stall.
module mac_accumulator
   import mac_accumulator_pkg::*;
#(
   parameter mac_cfg_t    CVA6Cfg   = cva6_cfg_empty,
   parameter int unsigned TAG_DEPTH = 4,
   localparam int unsigned XLEN = CVA6Cfg.xlen,
   localparam int unsigned TIDW = CVA6Cfg.trans_id_bits
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            issue_valid_i,
   input  logic [TIDW-1:0] trans_id_i,
   input  logic [1:0]      acc_op_i,
   input  logic [4:0]      shamt_i,
   input  logic            dot_valid_i,
   input  logic [17:0]     dot_i,
   output logic            issue_ready_o,
   output logic [XLEN-1:0] result_o,
   output logic [TIDW-1:0] trans_id_o,
   output logic            valid_o,
   input  logic            wb_ready_i,
   output logic            sat_o
);
   localparam int unsigned CW = $clog2(TAG_DEPTH) + 1;

   typedef struct packed {
      logic [TIDW-1:0] trans_id;
      mac_acc_op_t     op;
      logic [4:0]      shamt;
   } tag_entry_t;

   tag_entry_t             tag_in, tag_head;
   logic                   tag_push, tag_pop, tag_empty;
   logic [CW-1:0]          tag_count, res_count;
   logic                   res_pop, res_empty;
   logic [XLEN+TIDW-1:0]   res_in, res_head;
   logic [CW:0]            occupancy;

   logic signed [31:0] acc_q, acc_d;
   logic               sat_q, sat_d;
   logic [32:0]        sum33;
   logic [31:0]        t32, res32;
   logic               sum_ovf, clip;
   logic signed [32:0] rnd33, rq33, shifted;
   logic [7:0]         q8;

   assign occupancy     = {1'b0, tag_count} + {1'b0, res_count};
   assign issue_ready_o = (occupancy < (CW+1)'(TAG_DEPTH));
   assign tag_push      = issue_valid_i && issue_ready_o && !flush_i;
   assign tag_pop       = dot_valid_i && !flush_i && !tag_empty;
   assign tag_in        = '{trans_id: trans_id_i, op: mac_acc_op_t'(acc_op_i), shamt: shamt_i};

   mac_tag_fifo #(.WIDTH($bits(tag_entry_t)), .DEPTH(TAG_DEPTH)) u_tag_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .push_i  (tag_push),
      .data_i  (tag_in),
      .pop_i   (tag_pop),
      .data_o  (tag_head),
      .empty_o (tag_empty),
      .count_o (tag_count)
   );

   always_comb begin
      sum33   = {acc_q[31], acc_q} + {{15{dot_i[17]}}, dot_i};
      sum_ovf = sum33[32] ^ sum33[31];
      t32     = sat32(sum33);
      rnd33   = (tag_head.shamt == 5'd0) ? 33'sd0 : (33'sd1 <<< (tag_head.shamt - 5'd1));
      rq33    = $signed({t32[31], t32}) + rnd33;
      shifted = rq33 >>> tag_head.shamt;
      clip    = 1'b0;
      q8      = shifted[7:0];
      if (shifted > 33'sd127) begin
         q8   = 8'h7F;
         clip = 1'b1;
      end else if (shifted < -33'sd128) begin
         q8   = 8'h80;
         clip = 1'b1;
      end

      acc_d = acc_q;
      sat_d = sat_q;
      res32 = '0;
      if (tag_pop) begin
         case (tag_head.op)
            MAC_ACC: begin
               acc_d = t32;
               res32 = t32;
               sat_d = sat_q | sum_ovf;
            end
            MAC_NEW: begin
               acc_d = {{14{dot_i[17]}}, dot_i};
               res32 = {{14{dot_i[17]}}, dot_i};
            end
            MAC_RDQ: begin
               acc_d = '0;
               res32 = {{24{q8[7]}}, q8};
               sat_d = sat_q | sum_ovf | clip;
            end
            default: res32 = acc_q;
         endcase
      end
   end

   // Result is written at the pop edge, so it is at the queue head one cycle after dot_valid_i.
   assign res_in  = {XLEN'($signed(res32)), tag_head.trans_id};
   assign res_pop = valid_o && wb_ready_i;

   mac_tag_fifo #(.WIDTH(XLEN + TIDW), .DEPTH(TAG_DEPTH)) u_res_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (1'b0),
      .push_i  (tag_pop),
      .data_i  (res_in),
      .pop_i   (res_pop),
      .data_o  (res_head),
      .empty_o (res_empty),
      .count_o (res_count)
   );

   assign valid_o    = !res_empty;
   assign result_o   = res_head[XLEN+TIDW-1:TIDW];
   assign trans_id_o = res_head[TIDW-1:0];
   assign sat_o      = sat_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         acc_q <= '0;
         sat_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         sat_q <= sat_d;
      end
   end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 SHALL have parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, CVA6 configuration.
REQ-002 SHALL have parameter TAG_DEPTH, default 4, tag/result FIFO depth (power of two, ≥4).
REQ-003 SHALL have ports:
- clk_i  in  1  single clock.
- rst_i  in  1  reset, asynchronous, active-low.
- flush_i  in  1  pipeline flush.
- issue_valid_i  in  1  MAC instruction issued, same cycle as MAC unit's mac_valid_i.
- trans_id_i  in  TRANS_ID_BITS  instruction tag.
- acc_op_i  in  2  mac_acc_op_t.
- shamt_i  in  5  requantisation shift.
- dot_valid_i  in  1  MAC unit's mac_valid_o.
- dot_i  in  18  signed dot product, low 18 bits of MAC unit's result_o.
- issue_ready_o  out  1  may accept an issue.
- result_o  out  XLEN  writeback data.
- trans_id_o  out  TRANS_ID_BITS  writeback tag.
- valid_o  out  1  writeback valid.
- wb_ready_i  in  1  writeback accepts.
- sat_o  out  1  sticky saturation flag.

Function
REQ-004 SHALL push {trans_id_i, acc_op_i, shamt_i} into the tag FIFO when issue_valid_i && issue_ready_o && !flush_i.
REQ-005 SHALL pop the tag FIFO head when dot_valid_i && !flush_i; each popped tag pairs with dot_i, in order.
REQ-006 On dot_valid_i with the tag FIFO empty, SHALL drop dot_i with no state change (bench assertion fires).
REQ-007 SHALL hold a 32-bit signed accumulator acc; next value per popped op:
- ACC: sat32(acc + sext(dot_i)); result = new acc.
- NEW: acc = sext(dot_i); result = new acc.
- RDQ: t = sat32(acc + sext(dot_i)); result = sext64/32(clip8((t + (shamt ? 1<<(shamt-1) : 0)) >>> shamt)); acc = 0.
- PEEK: acc unchanged; result = acc.
REQ-008 sat32 SHALL clamp to 0x7FFF_FFFF / 0x8000_0000; clip8 SHALL clamp to 127 / -128; rounding add SHALL be computed in 33 bits.
REQ-009 sat_o SHALL set on any sat32 or clip8 clamp and stay set until reset.
REQ-010 SHALL write {result, tag} into the result FIFO in the cycle after the pop; if the FIFO is empty, valid_o SHALL rise that cycle (1-cycle latency dot_valid_i→valid_o).
REQ-011 valid_o/result_o/trans_id_o SHALL present the result FIFO head; pop on valid_o && wb_ready_i; outputs SHALL be stable while valid_o && !wb_ready_i.
REQ-012 issue_ready_o SHALL = (tags in flight + results queued + staged result) < TAG_DEPTH, so MAC results, which cannot stall, never overflow.
REQ-013 Simultaneous push and pop on either FIFO SHALL keep occupancy unchanged; pointers SHALL wrap modulo TAG_DEPTH.
REQ-014 flush_i SHALL empty the tag FIFO and discard any dot_valid_i in that cycle; acc, sat_o and the result FIFO SHALL be preserved (results are committed instructions).
REQ-015 Back-to-back dot_valid_i every cycle SHALL update acc every cycle with no bubble.

Reset
REQ-016 While rst_i=0 SHALL force: acc=0, sat_o=0, both FIFOs empty, valid_o=0, result_o=0, trans_id_o=0, issue_ready_o=1.
REQ-017 Reset mid-operation SHALL discard all in-flight tags and queued results; the first issue after release SHALL behave as from power-up.

Structure
REQ-018 mac_acc_op_t (ACC=0, NEW=1, RDQ=2, PEEK=3) and the tag entry struct SHALL live in ariane_pkg beside the MAC definitions.
REQ-019 Both FIFOs SHALL instantiate one sub-module, mac_tag_fifo, parameterised by width and depth, with flush input.

Verification
REQ-020 NEW dot=100, then ACC dot=-30 → results 100, 70; trans_ids in issue order; valid_o one cycle after each dot_valid_i.
REQ-021 acc=0x7FFF_FF00, ACC dot=0x1FFFF → result 0x7FFF_FFFF, sat_o=1.
REQ-022 acc=1000, RDQ dot=0, shamt=3 → result 125; acc=10000, shamt=2 → result 127 (clip), sat_o=1; next PEEK → 0.
REQ-023 wb_ready_i=0 with four issues → issue_ready_o=0 after the 4th; results held stable; release wb_ready_i → four results drain in order.
REQ-024 Two issues, flush_i coincident with the first dot_valid_i → no result, acc unchanged, tag FIFO empty, issue_ready_o=1.
REQ-025 rst_i low while three results are queued → valid_o=0 and acc=0 at once; post-release NEW dot=5 → result 5.
